alu_arbiter: RTL
================

# alu_arbiter

Two-requester arbiter and sequencer that shares the single combinational ALU datapath. Each requester submits an operation (operands, opcode, shift/carry-in) over a valid/ready handshake. The block grants one requester at a time with round-robin priority, drives the external ALU for one execute cycle, and returns the registered result and flags through a one-entry response buffer per requester. It sits between the core's issue logic (requester 0) and an auxiliary unit such as an address/loop engine (requester 1) and the ALU instance.

## Interface
- W, 8: operand/result width; must match the ALU's W.
- Ops, 4: opcode width; must match the ALU's Ops.
- Clk in 1: the only clock, rising-edge.
- Reset in 1: asynchronous, active-low. 0 forces reset state immediately; deassertion is synchronous to Clk by the upstream reset synchronizer.
- reqN_valid in 1 (N=0,1): requester N presents an operation.
- reqN_ready out 1: operation accepted on a cycle where valid and ready are both 1.
- reqN_a, reqN_b in W: operands.
- reqN_op in Ops: ALU opcode (op_mne encoding).
- reqN_sc in 1: shift/carry-in.
- rspN_valid out 1: result held for requester N.
- rspN_ready in 1: requester N consumes the result.
- rspN_out out W: result.
- rspN_zero, rspN_parity, rspN_odd out 1: ALU flags captured with the result.
- alu_a, alu_b out W: to ALU InputA, InputB.
- alu_op out Ops: to ALU OP.
- alu_sc out 1: to ALU SC_in.
- alu_out in W: from ALU Out.
- alu_zero, alu_parity, alu_odd in 1: from ALU flags.
- busy out 1: 1 while in EXEC.

## Operation
- FSM states: IDLE, EXEC.
- Eligibility: requester N is eligible in IDLE when reqN_valid=1 and rspN_valid=0. A response slot that drains in the current cycle still counts as full; there is no bypass.
- Arbitration in IDLE: if exactly one requester is eligible, it wins. If both are eligible, the requester that is not last_grant wins. reqN_ready=1 only for the winner, combinationally, in that cycle. All ready outputs are 0 in EXEC.
- On accept: latch a, b, op, sc and the owner index into operand registers; set last_grant to the winner; move IDLE→EXEC.
- EXEC: alu_* outputs come from the operand registers. At the end of the cycle, capture alu_out and the three flags into the owner's response slot, set rspOwner_valid=1, and return to IDLE.
- IDLE with no eligible requester: stay in IDLE. alu_* keep their last latched values; ALU outputs are ignored.
- Response slot: rspN_valid clears on the cycle rspN_valid and rspN_ready are both 1. Data stays stable while valid=1.
- Requesters hold valid and operands stable until ready. The block does not check this.
- The arbiter does not interpret opcodes; the ALU's behaviour fully defines the results.

## Timing
- Reset values: state IDLE; last_grant=1 (requester 0 wins the first tie); operand registers, alu_a, alu_b, alu_op, alu_sc = 0; rspN_valid=0; rspN_out and all flags = 0; reqN_ready=0; busy=0.
- Latency: accept at rising edge k → EXEC during cycle k..k+1 → rspN_valid=1 after edge k+1, i.e. one cycle after acceptance.
- Throughput: at most one operation per 2 cycles across both requesters. Continuous contention alternates 0,1,0,1.
- Simultaneous events: a response drain and a new accept from the same requester in one cycle is impossible, because the slot is full that cycle. Requester 0 finishing (EXEC) while requester 1 drains rsp1 is legal and independent.
- Reset asserted mid-EXEC: the in-flight operation is discarded, no response is written, and all registers take reset values asynchronously.
- A full response slot blocks only its own requester. The other requester may still be granted.

## Test plan
- Single op: req0 ADD a=8'h05 b=8'h03, rsp0_ready=1 → req0_ready=1 in cycle 0; rsp0_valid=1 after edge 2; out=8'h08, zero=0, parity=1, odd=0; busy=1 for exactly one cycle.
- Flags: req1 SUB a=8'h07 b=8'h07 → rsp1_out=8'h00, zero=1, parity=0, odd=0.
- Tie after reset: both request ADD every cycle with rsp ready=1 → grants alternate 0,1,0,1. Accept edges are 2 cycles apart and no operation is lost.
- Backpressure: rsp0_ready=0 with rsp0 full, both valid → only requester 1 is granted repeatedly. rsp0_out holds stable. Raising rsp0_ready for one cycle frees the slot, and requester 0 is granted the next IDLE cycle after that.
- Reset mid-EXEC: drop Reset during EXEC of a req0 op → rsp0_valid stays 0 and last_grant returns to 1. After release, a tie grants requester 0.
- No request: both valid=0 for 10 cycles → state stays IDLE, busy=0, all ready=0, and no rsp_valid is asserted.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. Requester 0 is
// normally the core issue logic, requester 1 an auxiliary unit (address/loop
// engine). One operation is in flight at a time: the winner's operands are
// latched, driven to the ALU for one EXEC cycle, and the ALU result plus flags
// are captured into the winner's one-entry response slot.
//
// Handshake rule (applies to every valid/ready pair below): a transfer happens
// on a rising clk edge where valid and ready are both 1. The producer holds
// valid and its payload stable until that edge; ready never depends on the
// payload, only on valid, slot occupancy, FSM state and last_grant.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req0_* / req1_*               operation request: valid/ready, a, b, op, sc
//   rsp0_* / rsp1_*               result slot: valid/ready, out, zero/parity/odd
//   alu_a, alu_b, alu_op, alu_sc  operand drive to the external ALU
//   alu_out, alu_zero,
//   alu_parity, alu_odd           result and flags from the external ALU
//   busy                          1 while in EXEC
//   dbg_state                     FSM state (0 = IDLE, 1 = EXEC)
//   dbg_last_grant                requester granted most recently
//   dbg_owner                     requester owning the latched operands
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int W   = 8,
   parameter int OPS = 4
) (
   input  logic           clk,
   input  logic           rst_n,

   // requester 0
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic [OPS-1:0] req0_op,
   input  logic           req0_sc,

   // requester 1
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   input  logic [OPS-1:0] req1_op,
   input  logic           req1_sc,

   // response slot 0
   output logic           rsp0_valid,
   input  logic           rsp0_ready,
   output logic [W-1:0]   rsp0_out,
   output logic           rsp0_zero,
   output logic           rsp0_parity,
   output logic           rsp0_odd,

   // response slot 1
   output logic           rsp1_valid,
   input  logic           rsp1_ready,
   output logic [W-1:0]   rsp1_out,
   output logic           rsp1_zero,
   output logic           rsp1_parity,
   output logic           rsp1_odd,

   // external ALU
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [OPS-1:0] alu_op,
   output logic           alu_sc,
   input  logic [W-1:0]   alu_out,
   input  logic           alu_zero,
   input  logic           alu_parity,
   input  logic           alu_odd,

   // status / debug
   output logic           busy,
   output logic           dbg_state,
   output logic           dbg_last_grant,
   output logic           dbg_owner
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_t;

   state_t         state;
   logic           last_grant;
   logic           owner;

   // latched operands; these drive the ALU directly and therefore hold their
   // last value while the arbiter is idle
   logic [W-1:0]   opnd_a;
   logic [W-1:0]   opnd_b;
   logic [OPS-1:0] opnd_op;
   logic           opnd_sc;

   logic           elig0;
   logic           elig1;
   logic           grant0;
   logic           grant1;
   logic           grant_any;

   // ---------------------------------------------------------------------------
   // Arbitration
   // A requester whose response slot is still occupied is not eligible, even
   // if that slot is being drained this very cycle: there is no bypass, so a
   // slot can never be refilled before the old result has left.
   // On a tie the requester that did not win last time goes first.
   // ---------------------------------------------------------------------------
   always_comb begin
      elig0     = 1'b0;
      elig1     = 1'b0;
      grant0    = 1'b0;
      grant1    = 1'b0;
      grant_any = 1'b0;
      if (state == S_IDLE) begin
         elig0 = req0_valid && !rsp0_valid;
         elig1 = req1_valid && !rsp1_valid;
      end
      grant0    = elig0 && (!elig1 || (last_grant == 1'b1));
      grant1    = elig1 && (!elig0 || (last_grant == 1'b0));
      grant_any = grant0 || grant1;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign alu_a  = opnd_a;
   assign alu_b  = opnd_b;
   assign alu_op = opnd_op;
   assign alu_sc = opnd_sc;

   assign busy           = (state == S_EXEC);
   assign dbg_state      = state;
   assign dbg_last_grant = last_grant;
   assign dbg_owner      = owner;

   // ---------------------------------------------------------------------------
   // Sequencer, operand registers and response slots
   // The drain of a slot and the EXEC write-back never target the same slot
   // in one cycle: the owner's slot was empty when it was granted and nothing
   // else can fill it, so the write-back simply follows the drain below.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         last_grant  <= 1'b1;
         owner       <= 1'b0;
         opnd_a      <= '0;
         opnd_b      <= '0;
         opnd_op     <= '0;
         opnd_sc     <= 1'b0;
         rsp0_valid  <= 1'b0;
         rsp0_out    <= '0;
         rsp0_zero   <= 1'b0;
         rsp0_parity <= 1'b0;
         rsp0_odd    <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp1_out    <= '0;
         rsp1_zero   <= 1'b0;
         rsp1_parity <= 1'b0;
         rsp1_odd    <= 1'b0;
      end else begin
         // consumer side of the response slots
         if (rsp0_valid && rsp0_ready) begin
            rsp0_valid <= 1'b0;
         end
         if (rsp1_valid && rsp1_ready) begin
            rsp1_valid <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  if (grant1) begin
                     opnd_a  <= req1_a;
                     opnd_b  <= req1_b;
                     opnd_op <= req1_op;
                     opnd_sc <= req1_sc;
                  end else begin
                     opnd_a  <= req0_a;
                     opnd_b  <= req0_b;
                     opnd_op <= req0_op;
                     opnd_sc <= req0_sc;
                  end
                  owner      <= grant1;
                  last_grant <= grant1;
                  state      <= S_EXEC;
               end
            end

            S_EXEC: begin
               // the ALU has had the whole cycle to settle on opnd_*
               if (owner) begin
                  rsp1_valid  <= 1'b1;
                  rsp1_out    <= alu_out;
                  rsp1_zero   <= alu_zero;
                  rsp1_parity <= alu_parity;
                  rsp1_odd    <= alu_odd;
               end else begin
                  rsp0_valid  <= 1'b1;
                  rsp0_out    <= alu_out;
                  rsp0_zero   <= alu_zero;
                  rsp0_parity <= alu_parity;
                  rsp0_odd    <= alu_odd;
               end
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
